// File: rtl/result_framer.sv
// rtl/result_framer.sv - frames ADC and timestamp records into 16-bit host FIFO words
// Optional trailing XOR checksum word: define RESULT_FRAMER_CHECKSUM_EN.

module result_framer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adc_valid,
  input  logic [3:0]  adc_dev,
  input  logic [13:0] adc_data,
  output logic        adc_ready,
  input  logic        time_valid,
  input  logic [47:0] time_data,
  output logic        time_ready,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [15:0] fifo_din,
  output logic        frame_done,
  output logic [7:0]  seq
);

`ifdef RESULT_FRAMER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, PAYLOAD = 2'd2, CHK = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, PAYLOAD = 2'd2} state_t;
`endif

  state_t      state, state_nxt;
  logic        armed;
  logic        is_time;
  logic [47:0] payload;
  logic [1:0]  idx;
  logic [15:0] din_q;
  logic [7:0]  seq_q;
  logic        done_q;
  logic        last_pl;
  logic        frame_end;
`ifdef RESULT_FRAMER_CHECKSUM_EN
  logic [15:0] csum;
`endif

  // Payload words are stored left-justified so word k is always the k-th 16-bit slice.
  function automatic logic [15:0] pick_word(input logic [47:0] p, input logic [1:0] k);
    case (k)
      2'd0:    pick_word = p[47:32];
      2'd1:    pick_word = p[31:16];
      default: pick_word = p[15:0];
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    adc_ready  = 1'b0;
    time_ready = 1'b0;
    fifo_wr_en = 1'b0;
    frame_end  = 1'b0;
    last_pl    = (idx == (is_time ? 2'd2 : 2'd0));
    case (state)
      IDLE: begin
        // armed is cleared by reset, so ready stays low while rst_n is low and for one edge after
        adc_ready  = armed;
        time_ready = armed & ~adc_valid;
        if (armed && (adc_valid || time_valid)) state_nxt = HDR;
      end
      HDR: begin
        fifo_wr_en = ~fifo_full;
        if (!fifo_full) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        fifo_wr_en = ~fifo_full;
        if (!fifo_full && last_pl) begin
`ifdef RESULT_FRAMER_CHECKSUM_EN
          state_nxt = CHK;
`else
          state_nxt = IDLE;
          frame_end = 1'b1;
`endif
        end
      end
`ifdef RESULT_FRAMER_CHECKSUM_EN
      CHK: begin
        fifo_wr_en = ~fifo_full;
        if (!fifo_full) begin
          state_nxt = IDLE;
          frame_end = 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed   <= 1'b0;
      is_time <= 1'b0;
      payload <= '0;
      idx     <= '0;
      din_q   <= '0;
      seq_q   <= '0;
      done_q  <= 1'b0;
`ifdef RESULT_FRAMER_CHECKSUM_EN
      csum    <= '0;
`endif
    end else begin
      armed  <= 1'b1;
      done_q <= frame_end;
      if (frame_end) seq_q <= seq_q + 8'd1;
      if (state == IDLE) begin
        if (adc_ready && adc_valid) begin
          is_time <= 1'b0;
          payload <= {2'b00, adc_data, 32'h0};
          din_q   <= {4'hA, adc_dev, seq_q};
          idx     <= 2'd0;
`ifdef RESULT_FRAMER_CHECKSUM_EN
          csum    <= '0;
`endif
        end else if (time_ready && time_valid) begin
          is_time <= 1'b1;
          payload <= time_data;
          din_q   <= {4'hC, 4'h0, seq_q};
          idx     <= 2'd0;
`ifdef RESULT_FRAMER_CHECKSUM_EN
          csum    <= '0;
`endif
        end
      end else if (fifo_wr_en) begin
`ifdef RESULT_FRAMER_CHECKSUM_EN
        csum <= csum ^ din_q;
`endif
        if (state == HDR) begin
          din_q <= pick_word(payload, 2'd0);
        end else if (state == PAYLOAD) begin
          if (!last_pl) begin
            idx   <= idx + 2'd1;
            din_q <= pick_word(payload, idx + 2'd1);
          end
`ifdef RESULT_FRAMER_CHECKSUM_EN
          else begin
            din_q <= csum ^ din_q;
          end
`endif
        end
      end
    end
  end

  assign fifo_din   = din_q;
  assign seq        = seq_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_result_framer.sv
// tb/tb_result_framer.sv - directed self-checking bench for result_framer
// Expected words include the checksum word when RESULT_FRAMER_CHECKSUM_EN is defined.

module tb_result_framer;

`ifdef RESULT_FRAMER_CHECKSUM_EN
  localparam int NW_ADC  = 3;
  localparam int NW_TIME = 5;
`else
  localparam int NW_ADC  = 2;
  localparam int NW_TIME = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        adc_valid = 1'b0;
  logic [3:0]  adc_dev = '0;
  logic [13:0] adc_data = '0;
  logic        time_valid = 1'b0;
  logic [47:0] time_data = '0;
  logic        fifo_full = 1'b0;
  logic        adc_ready, time_ready, fifo_wr_en, frame_done;
  logic [15:0] fifo_din;
  logic [7:0]  seq;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [15:0] wq[$];
  int          wcyc[$];
  logic [15:0] exp[$];

  result_framer dut (
    .clk(clk), .rst_n(rst_n),
    .adc_valid(adc_valid), .adc_dev(adc_dev), .adc_data(adc_data), .adc_ready(adc_ready),
    .time_valid(time_valid), .time_data(time_data), .time_ready(time_ready),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
    .frame_done(frame_done), .seq(seq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every written word with the cycle it was written in.
  always @(negedge clk) begin
    if (rst_n && fifo_wr_en) begin
      wq.push_back(fifo_din);
      wcyc.push_back(cyc);
    end
  end

  function automatic logic [15:0] wq_at(int i);
    if (i < wq.size()) return wq[i];
    return 16'hxxxx;
  endfunction

  function automatic int wcyc_at(int i);
    if (i < wcyc.size()) return wcyc[i];
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    wq.delete();
    wcyc.delete();
    exp.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; adc_valid = 1'b1; time_valid = 1'b1; adc_dev = 4'h3; adc_data = 14'h1ABC;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %0h expected 0", fifo_wr_en); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %0h expected 0", frame_done); end
    n_checks++; if (seq !== 8'h00) begin n_fail++; $display("FAIL reset_seq: got %0h expected 00", seq); end
    n_checks++; if (fifo_din !== 16'h0000) begin n_fail++; $display("FAIL reset_fifo_din: got %0h expected 0000", fifo_din); end
    n_checks++; if (adc_ready !== 1'b0) begin n_fail++; $display("FAIL reset_adc_ready: got %0h expected 0", adc_ready); end
    n_checks++; if (time_ready !== 1'b0) begin n_fail++; $display("FAIL reset_time_ready: got %0h expected 0", time_ready); end
    tick();
    rst_n = 1'b1; adc_valid = 1'b0; time_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (adc_ready !== 1'b0) begin n_fail++; $display("FAIL release_ready_first_cycle: got %0h expected 0", adc_ready); end
    tick();
    @(negedge clk);
    n_checks++; if (adc_ready !== 1'b1) begin n_fail++; $display("FAIL release_adc_ready_second: got %0h expected 1", adc_ready); end
    n_checks++; if (time_ready !== 1'b1) begin n_fail++; $display("FAIL release_time_ready_second: got %0h expected 1", time_ready); end
    tick();
  endtask

  task automatic test_adc_frame();
    int acc, done_c;
    bit got;
    clear_log();
    adc_dev = 4'h3; adc_data = 14'h1ABC; adc_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (adc_ready !== 1'b1) begin n_fail++; $display("FAIL adc_ready: got %0h expected 1", adc_ready); end
    acc = cyc;
    tick();
    adc_valid = 1'b0; adc_dev = 4'hF; adc_data = 14'h3FFF;
    got = 0; done_c = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (frame_done) begin got = 1; done_c = cyc; break; end
    end
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL adc_done_timeout: got %0d expected 1", got); end
    exp.push_back(16'hA300); exp.push_back(16'h1ABC);
`ifdef RESULT_FRAMER_CHECKSUM_EN
    exp.push_back(16'hB9BC);
`endif
    n_checks++; if (wq.size() != NW_ADC) begin n_fail++; $display("FAIL adc_word_count: got %0d expected %0d", wq.size(), NW_ADC); end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++; if (wq_at(i) !== exp[i]) begin n_fail++; $display("FAIL adc_word%0d: got %h expected %h", i, wq_at(i), exp[i]); end
      n_checks++; if (wcyc_at(i) != acc + 1 + i) begin n_fail++; $display("FAIL adc_word%0d_cycle: got %0d expected %0d", i, wcyc_at(i), acc + 1 + i); end
    end
    n_checks++; if (done_c != acc + NW_ADC + 1) begin n_fail++; $display("FAIL adc_done_cycle: got %0d expected %0d", done_c, acc + NW_ADC + 1); end
    n_checks++; if (seq !== 8'd1) begin n_fail++; $display("FAIL adc_seq_after: got %0d expected 1", seq); end
    tick();
  endtask

  task automatic test_back_to_back();
    int acc[4];
    int k, dn;
    bit took;
    logic [15:0] hdr, pl;
    clear_log();
    k = 0; dn = 0;
    adc_dev = 4'h1; adc_data = 14'h2000; adc_valid = 1'b1;
    for (int n = 0; n < 60 && dn < 4; n++) begin
      @(negedge clk);
      took = adc_ready && adc_valid;
      if (took) begin acc[k] = cyc; k++; end
      if (frame_done) dn++;
      tick();
      if (took) begin
        if (k == 4) adc_valid = 1'b0;
        else begin adc_dev = 4'(k + 1); adc_data = 14'h2000 | 14'(k); end
      end
    end
    n_checks++; if (dn != 4) begin n_fail++; $display("FAIL b2b_frames_done: got %0d expected 4", dn); end
    for (int j = 0; j < 4; j++) begin
      hdr = {4'hA, 4'(j + 1), 8'(1 + j)};
      pl  = {2'b00, 14'h2000 | 14'(j)};
      n_checks++; if (wq_at(j * NW_ADC) !== hdr) begin n_fail++; $display("FAIL b2b_hdr%0d: got %h expected %h", j, wq_at(j * NW_ADC), hdr); end
      n_checks++; if (wq_at(j * NW_ADC + 1) !== pl) begin n_fail++; $display("FAIL b2b_data%0d: got %h expected %h", j, wq_at(j * NW_ADC + 1), pl); end
    end
    for (int j = 1; j < 4; j++) begin
      n_checks++; if (acc[j] != acc[j-1] + NW_ADC + 1) begin n_fail++; $display("FAIL b2b_accept_gap%0d: got %0d expected %0d", j, acc[j] - acc[j-1], NW_ADC + 1); end
    end
    n_checks++; if (seq !== 8'd5) begin n_fail++; $display("FAIL b2b_seq_after: got %0d expected 5", seq); end
  endtask

  task automatic test_time_frame();
    int acc;
    bit got;
    clear_log();
    time_data = 48'h0123_4567_89AB; time_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (time_ready !== 1'b1) begin n_fail++; $display("FAIL time_ready: got %0h expected 1", time_ready); end
    acc = cyc;
    tick();
    time_valid = 1'b0; time_data = '1;
    got = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (frame_done) begin got = 1; break; end
    end
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL time_done_timeout: got %0d expected 1", got); end
    exp.push_back(16'hC005); exp.push_back(16'h0123); exp.push_back(16'h4567); exp.push_back(16'h89AB);
`ifdef RESULT_FRAMER_CHECKSUM_EN
    exp.push_back(16'hC005 ^ 16'h0123 ^ 16'h4567 ^ 16'h89AB);
`endif
    n_checks++; if (wq.size() != NW_TIME) begin n_fail++; $display("FAIL time_word_count: got %0d expected %0d", wq.size(), NW_TIME); end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++; if (wq_at(i) !== exp[i]) begin n_fail++; $display("FAIL time_word%0d: got %h expected %h", i, wq_at(i), exp[i]); end
      n_checks++; if (wcyc_at(i) != acc + 1 + i) begin n_fail++; $display("FAIL time_word%0d_cycle: got %0d expected %0d", i, wcyc_at(i), acc + 1 + i); end
    end
    n_checks++; if (seq !== 8'd6) begin n_fail++; $display("FAIL time_seq_after: got %0d expected 6", seq); end
    tick();
  endtask

  task automatic test_simultaneous();
    int adc_acc, time_acc, dn;
    bit ta, tt;
    clear_log();
    adc_acc = -1; time_acc = -1; dn = 0;
    adc_dev = 4'h5; adc_data = 14'h0123; adc_valid = 1'b1;
    time_data = 48'hFEDC_BA98_7654; time_valid = 1'b1;
    for (int n = 0; n < 60 && dn < 2; n++) begin
      @(negedge clk);
      ta = adc_ready && adc_valid;
      tt = time_ready && time_valid;
      if (ta) begin
        adc_acc = cyc;
        n_checks++; if (time_ready !== 1'b0) begin n_fail++; $display("FAIL simul_time_ready_at_adc_accept: got %0h expected 0", time_ready); end
      end
      if (tt) time_acc = cyc;
      if (frame_done) dn++;
      tick();
      if (ta) adc_valid = 1'b0;
      if (tt) time_valid = 1'b0;
    end
    n_checks++; if (dn != 2) begin n_fail++; $display("FAIL simul_frames_done: got %0d expected 2", dn); end
    n_checks++; if (time_acc != adc_acc + NW_ADC + 1) begin n_fail++; $display("FAIL simul_time_accept_cycle: got %0d expected %0d", time_acc, adc_acc + NW_ADC + 1); end
    exp.push_back(16'hA506); exp.push_back(16'h0123);
`ifdef RESULT_FRAMER_CHECKSUM_EN
    exp.push_back(16'hA506 ^ 16'h0123);
`endif
    exp.push_back(16'hC007); exp.push_back(16'hFEDC); exp.push_back(16'hBA98); exp.push_back(16'h7654);
`ifdef RESULT_FRAMER_CHECKSUM_EN
    exp.push_back(16'hC007 ^ 16'hFEDC ^ 16'hBA98 ^ 16'h7654);
`endif
    n_checks++; if (wq.size() != exp.size()) begin n_fail++; $display("FAIL simul_word_count: got %0d expected %0d", wq.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++; if (wq_at(i) !== exp[i]) begin n_fail++; $display("FAIL simul_word%0d: got %h expected %h", i, wq_at(i), exp[i]); end
    end
    n_checks++; if (seq !== 8'd8) begin n_fail++; $display("FAIL simul_seq_after: got %0d expected 8", seq); end
  endtask

  task automatic test_stall();
    int acc;
    bit got;
    clear_log();
    acc = -1; got = 0;
    time_data = 48'h1111_2222_3333;
    for (int k = 0; k < 30; k++) begin
      fifo_full = (k >= 2 && k <= 5);
      time_valid = (k == 0);
      @(negedge clk);
      if (k == 0) begin
        acc = cyc;
        n_checks++; if (time_ready !== 1'b1) begin n_fail++; $display("FAIL stall_accept: got %0h expected 1", time_ready); end
      end
      if (k >= 2 && k <= 5) begin
        n_checks++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL stall_wr_en_k%0d: got %0h expected 0", k, fifo_wr_en); end
        n_checks++; if (fifo_din !== 16'h1111) begin n_fail++; $display("FAIL stall_din_hold_k%0d: got %h expected 1111", k, fifo_din); end
      end
      if (frame_done) begin got = 1; tick(); break; end
      tick();
    end
    fifo_full = 1'b0; time_valid = 1'b0;
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL stall_done_timeout: got %0d expected 1", got); end
    exp.push_back(16'hC008); exp.push_back(16'h1111); exp.push_back(16'h2222); exp.push_back(16'h3333);
`ifdef RESULT_FRAMER_CHECKSUM_EN
    exp.push_back(16'hC008 ^ 16'h1111 ^ 16'h2222 ^ 16'h3333);
`endif
    n_checks++; if (wq.size() != NW_TIME) begin n_fail++; $display("FAIL stall_word_count: got %0d expected %0d", wq.size(), NW_TIME); end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++; if (wq_at(i) !== exp[i]) begin n_fail++; $display("FAIL stall_word%0d: got %h expected %h", i, wq_at(i), exp[i]); end
      n_checks++; if (wcyc_at(i) != ((i == 0) ? acc + 1 : acc + 5 + i)) begin n_fail++; $display("FAIL stall_word%0d_cycle: got %0d expected %0d", i, wcyc_at(i), (i == 0) ? acc + 1 : acc + 5 + i); end
    end
    n_checks++; if (seq !== 8'd9) begin n_fail++; $display("FAIL stall_seq_after: got %0d expected 9", seq); end
  endtask

  task automatic test_seq_wrap();
    int acc, dn;
    logic [15:0] hdr;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    clear_log();
    acc = 0; dn = 0;
    adc_dev = 4'h6; adc_data = 14'h0AAA; adc_valid = 1'b1;
    for (int n = 0; n < 257 * (NW_ADC + 1) + 40 && dn < 257; n++) begin
      @(negedge clk);
      if (adc_ready && adc_valid) acc++;
      if (frame_done) dn++;
      tick();
      if (acc == 257) adc_valid = 1'b0;
    end
    adc_valid = 1'b0;
    n_checks++; if (dn != 257) begin n_fail++; $display("FAIL wrap_frames_done: got %0d expected 257", dn); end
    n_checks++; if (wq.size() != 257 * NW_ADC) begin n_fail++; $display("FAIL wrap_word_count: got %0d expected %0d", wq.size(), 257 * NW_ADC); end
    for (int i = 0; i < 257; i++) begin
      hdr = {4'hA, 4'h6, 8'(i)};
      n_checks++; if (wq_at(i * NW_ADC) !== hdr) begin n_fail++; $display("FAIL wrap_hdr%0d: got %h expected %h", i, wq_at(i * NW_ADC), hdr); end
    end
    n_checks++; if (seq !== 8'd1) begin n_fail++; $display("FAIL wrap_seq_after: got %0d expected 1", seq); end
  endtask

  task automatic test_reset_mid_frame();
    bit got;
    clear_log();
    time_data = 48'hAAAA_BBBB_CCCC; time_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (time_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_accept: got %0h expected 1", time_ready); end
    tick();
    time_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL midrst_wr_en: got %0h expected 0", fifo_wr_en); end
    n_checks++; if (seq !== 8'h00) begin n_fail++; $display("FAIL midrst_seq: got %0h expected 00", seq); end
    n_checks++; if (fifo_din !== 16'h0000) begin n_fail++; $display("FAIL midrst_fifo_din: got %h expected 0000", fifo_din); end
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    n_checks++; if (wq.size() != 2) begin n_fail++; $display("FAIL midrst_words_written: got %0d expected 2", wq.size()); end
    n_checks++; if (wq_at(0) !== 16'hC001) begin n_fail++; $display("FAIL midrst_word0: got %h expected C001", wq_at(0)); end
    n_checks++; if (wq_at(1) !== 16'hAAAA) begin n_fail++; $display("FAIL midrst_word1: got %h expected AAAA", wq_at(1)); end
    clear_log();
    adc_dev = 4'h9; adc_data = 14'h0055; adc_valid = 1'b1;
    got = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (adc_ready) begin got = 1; tick(); break; end
      tick();
    end
    adc_valid = 1'b0;
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL midrst_next_accept_timeout: got %0d expected 1", got); end
    got = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (frame_done) begin got = 1; break; end
    end
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL midrst_next_done_timeout: got %0d expected 1", got); end
    exp.push_back(16'hA900); exp.push_back(16'h0055);
`ifdef RESULT_FRAMER_CHECKSUM_EN
    exp.push_back(16'hA900 ^ 16'h0055);
`endif
    n_checks++; if (wq.size() != NW_ADC) begin n_fail++; $display("FAIL midrst_next_word_count: got %0d expected %0d", wq.size(), NW_ADC); end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++; if (wq_at(i) !== exp[i]) begin n_fail++; $display("FAIL midrst_next_word%0d: got %h expected %h", i, wq_at(i), exp[i]); end
    end
    n_checks++; if (seq !== 8'd1) begin n_fail++; $display("FAIL midrst_next_seq: got %0d expected 1", seq); end
    tick();
  endtask

  initial begin
    test_reset();
    test_adc_frame();
    test_back_to_back();
    test_time_frame();
    test_simultaneous();
    test_stall();
    test_seq_wrap();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
